// File: rtl/ita_package.sv
// Shared types and constants for the ITA weight path: weight word type,
// default reuse-count width and the weight feeder occupancy FSM encoding.
package ita_package;

  localparam int unsigned WEIGHT_W        = 8;
  localparam int unsigned REUSE_W_DEFAULT = 8;

  typedef logic [WEIGHT_W-1:0] weight_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/ita_weight_feeder_if.sv
// Upstream weight-word handshake into the weight feeder: valid/ready plus the
// weight word and its per-word reuse count.
interface ita_weight_feeder_if #(
  parameter int unsigned REUSE_W = ita_package::REUSE_W_DEFAULT
);
  import ita_package::*;

  logic               weight_valid_i;
  logic               weight_ready_o;
  weight_t            weight_i;
  logic [REUSE_W-1:0] reuse_i;

  modport master (
    output weight_valid_i,
    output weight_i,
    output reuse_i,
    input  weight_ready_o
  );

  modport slave (
    input  weight_valid_i,
    input  weight_i,
    input  reuse_i,
    output weight_ready_o
  );

endinterface

// File: rtl/ita_weight_feeder.sv
// Two-entry weight buffer that presents each word for `reuse` datapath steps.
// Optional macro ITA_WEIGHT_FEEDER_GATE_EN zeroes weight_o whenever calc_en_o is low.
module ita_weight_feeder
  import ita_package::*;
#(
  parameter int unsigned REUSE_W = REUSE_W_DEFAULT
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  ita_weight_feeder_if.slave up,
  input  logic    step_en_i,
  input  logic    flush_i,
  output logic    calc_en_o,
  output weight_t weight_o,
  output logic    busy_o
);

  typedef struct packed {
    weight_t            weight;
    logic [REUSE_W-1:0] reuse;
  } entry_t;

  entry_t             mem_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [REUSE_W-1:0] use_cnt_q;
  feeder_state_e      state_q;
  feeder_state_e      state_d;

  entry_t head;
  logic   ready;
  logic   push;
  logic   pop;
  logic   last_use;

  assign head      = mem_q[rd_ptr_q];
  assign ready     = (state_q != FULL);
  assign push      = up.weight_valid_i && ready;
  assign calc_en_o = step_en_i && (state_q != EMPTY);
  assign busy_o    = (state_q != EMPTY);

  assign up.weight_ready_o = ready;

  // A reuse count of 0 is presented once, same as 1.
  assign last_use = (head.reuse <= REUSE_W'(1)) ? (use_cnt_q == '0)
                                                : (use_cnt_q == head.reuse - REUSE_W'(1));
  assign pop      = calc_en_o && last_use;

`ifdef ITA_WEIGHT_FEEDER_GATE_EN
  assign weight_o = calc_en_o ? head.weight : '0;
`else
  assign weight_o = (state_q != EMPTY) ? head.weight : '0;
`endif

  // NOTE: every path through a combinational block assigns its outputs
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (push) state_d = HALF;
      HALF: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = HALF;
      default: state_d = EMPTY;
    endcase
    if (flush_i) state_d = EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  // NOTE: the storage is reset explicitly so weight_o has a defined value
  // out of reset; it is only two entries, so the reset net is cheap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      use_cnt_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      use_cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{weight: up.weight_i, reuse: up.reuse_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q  <= ~rd_ptr_q;
        use_cnt_q <= '0;
      end else if (calc_en_o) begin
        use_cnt_q <= use_cnt_q + REUSE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ita_weight_feeder.sv
// Self-checking bench for ita_weight_feeder: directed vector table, randomized
// traffic against a queue-based reference model, flush and reset sequences.
module tb_ita_weight_feeder;
  import ita_package::*;

`ifdef ITA_WEIGHT_FEEDER_GATE_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  logic    clk = 1'b0;
  logic    rst_n;
  logic    step_en;
  logic    flush;
  logic    calc_en;
  logic    busy;
  weight_t weight_out;

  ita_weight_feeder_if #(.REUSE_W(8)) up_if ();

  ita_weight_feeder #(.REUSE_W(8)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .up        (up_if.slave),
    .step_en_i (step_en),
    .flush_i   (flush),
    .calc_en_o (calc_en),
    .weight_o  (weight_out),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: queue of buffered words with their effective
  // presentation count, plus how many presentations the head has had.
  typedef struct {
    logic [7:0] w;
    int         eff;
  } ent_t;
  ent_t mq[$];
  int   m_used = 0;

  function automatic logic [7:0] exp_wout(input bit c, input bit b, input logic [7:0] h);
    if (GATED) return c ? h : 8'h00;
    return b ? h : 8'h00;
  endfunction

  task automatic drive(input bit v, input logic [7:0] w, input int r, input bit s, input bit f);
    up_if.weight_valid_i = v;
    up_if.weight_i       = w;
    up_if.reuse_i        = 8'(r);
    step_en              = s;
    flush                = f;
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    bit         b = (mq.size() > 0);
    bit         c = step_en && b;
    logic [7:0] h = b ? mq[0].w : 8'h00;
    check({tag, ".ready"},  32'(up_if.weight_ready_o), 32'(mq.size() < 2));
    check({tag, ".calc"},   32'(calc_en),              32'(c));
    check({tag, ".busy"},   32'(busy),                 32'(b));
    check({tag, ".weight"}, 32'(weight_out),           32'(exp_wout(c, b, h)));
  endtask

  task automatic advance();
    bit rdy = (mq.size() < 2);
    bit c   = step_en && (mq.size() > 0);
    @(posedge clk);
    if (flush) begin
      mq.delete();
      m_used = 0;
    end else begin
      if (c) begin
        m_used++;
        if (m_used == mq[0].eff) begin
          void'(mq.pop_front());
          m_used = 0;
        end
      end
      if (up_if.weight_valid_i && rdy)
        mq.push_back('{w: up_if.weight_i,
                       eff: (up_if.reuse_i == 8'd0) ? 1 : int'(up_if.reuse_i)});
    end
    #1;
  endtask

  typedef struct {
    bit         v;
    logic [7:0] w;
    int         r;
    bit         s;
    bit         f;
    bit         e_rdy;
    bit         e_calc;
    bit         e_busy;
    logic [7:0] e_head;
  } vec_t;

  function automatic vec_t mk(input bit v, input logic [7:0] w, input int r, input bit s,
                              input bit rdy, input bit c, input bit b, input logic [7:0] h);
    return '{v: v, w: w, r: r, s: s, f: 1'b0, e_rdy: rdy, e_calc: c, e_busy: b, e_head: h};
  endfunction

  vec_t tbl [24];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reuse 3, step held high: three presentations of 0x11
    tbl[0]  = mk(1, 8'h11, 3, 1, 1, 0, 0, 8'h00);
    tbl[1]  = mk(0, 8'h00, 0, 1, 1, 1, 1, 8'h11);
    tbl[2]  = mk(0, 8'h00, 0, 1, 1, 1, 1, 8'h11);
    tbl[3]  = mk(0, 8'h00, 0, 1, 1, 1, 1, 8'h11);
    tbl[4]  = mk(0, 8'h00, 0, 1, 1, 0, 0, 8'h00);
    // back-pressure: A3 waits for the first pop
    tbl[5]  = mk(1, 8'hA1, 1, 0, 1, 0, 0, 8'h00);
    tbl[6]  = mk(1, 8'hA2, 1, 0, 1, 0, 1, 8'hA1);
    tbl[7]  = mk(1, 8'hA3, 1, 0, 0, 0, 1, 8'hA1);
    tbl[8]  = mk(1, 8'hA3, 1, 0, 0, 0, 1, 8'hA1);
    tbl[9]  = mk(1, 8'hA3, 1, 1, 0, 1, 1, 8'hA1);
    tbl[10] = mk(1, 8'hA3, 1, 1, 1, 1, 1, 8'hA2);
    tbl[11] = mk(0, 8'h00, 0, 1, 1, 1, 1, 8'hA3);
    tbl[12] = mk(0, 8'h00, 0, 1, 1, 0, 0, 8'h00);
    // reuse 0 presents once
    tbl[13] = mk(1, 8'h5A, 0, 0, 1, 0, 0, 8'h00);
    tbl[14] = mk(0, 8'h00, 0, 1, 1, 1, 1, 8'h5A);
    tbl[15] = mk(0, 8'h00, 0, 1, 1, 0, 0, 8'h00);
    // reuse 4 with step pattern 1,0,1,0,1,1
    tbl[16] = mk(1, 8'h3C, 4, 0, 1, 0, 0, 8'h00);
    tbl[17] = mk(0, 8'h00, 0, 1, 1, 1, 1, 8'h3C);
    tbl[18] = mk(0, 8'h00, 0, 0, 1, 0, 1, 8'h3C);
    tbl[19] = mk(0, 8'h00, 0, 1, 1, 1, 1, 8'h3C);
    tbl[20] = mk(0, 8'h00, 0, 0, 1, 0, 1, 8'h3C);
    tbl[21] = mk(0, 8'h00, 0, 1, 1, 1, 1, 8'h3C);
    tbl[22] = mk(0, 8'h00, 0, 1, 1, 1, 1, 8'h3C);
    tbl[23] = mk(0, 8'h00, 0, 1, 1, 0, 0, 8'h00);

    // reset values, with step_en high to show calc_en is still blocked
    rst_n                = 1'b0;
    up_if.weight_valid_i = 1'b0;
    up_if.weight_i       = '0;
    up_if.reuse_i        = '0;
    step_en              = 1'b1;
    flush                = 1'b0;
    #12;
    check("reset.ready",  32'(up_if.weight_ready_o), 32'd1);
    check("reset.calc",   32'(calc_en),              32'd0);
    check("reset.weight", 32'(weight_out),           32'd0);
    check("reset.busy",   32'(busy),                 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].r, tbl[i].s, tbl[i].f);
      check($sformatf("vec%0d.ready", i),  32'(up_if.weight_ready_o), 32'(tbl[i].e_rdy));
      check($sformatf("vec%0d.calc", i),   32'(calc_en),              32'(tbl[i].e_calc));
      check($sformatf("vec%0d.busy", i),   32'(busy),                 32'(tbl[i].e_busy));
      check($sformatf("vec%0d.weight", i), 32'(weight_out),
            32'(exp_wout(tbl[i].e_calc, tbl[i].e_busy, tbl[i].e_head)));
      advance();
    end

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 9)) : int'($urandom_range(0, 3)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
      check_model($sformatf("rnd%0d", i));
      advance();
    end
    drive(0, 8'h00, 0, 0, 1);
    advance();

    // flush while FULL with counter at 2 and a word offered
    drive(1, 8'h21, 5, 0, 0); advance();
    drive(1, 8'h22, 5, 0, 0); advance();
    drive(0, 8'h00, 0, 1, 0); check_model("fl.s0"); advance();
    drive(0, 8'h00, 0, 1, 0); check_model("fl.s1"); advance();
    drive(1, 8'h23, 5, 1, 1); check_model("fl.assert"); advance();
    drive(0, 8'h00, 0, 1, 0);
    check("flush_full.busy",   32'(busy),                 32'd0);
    check("flush_full.ready",  32'(up_if.weight_ready_o), 32'd1);
    check("flush_full.calc",   32'(calc_en),              32'd0);
    check("flush_full.weight", 32'(weight_out),           32'd0);
    advance();

    // flush beats a push that HALF would otherwise accept
    drive(1, 8'h31, 2, 0, 0); advance();
    drive(1, 8'h32, 2, 1, 1); advance();
    drive(0, 8'h00, 0, 1, 0);
    check("flush_half.busy", 32'(busy),    32'd0);
    check("flush_half.calc", 32'(calc_en), 32'd0);
    advance();

    // idle buffered word: gated build hides it, ungated build shows it
    drive(1, 8'h55, 2, 0, 0); advance();
    drive(0, 8'h00, 0, 0, 0);
    check("idle.weight", 32'(weight_out), GATED ? 32'h00 : 32'h55);
    check_model("idle");
    advance();
    drive(0, 8'h00, 0, 1, 0); check_model("idle.d0"); advance();
    drive(0, 8'h00, 0, 1, 0); check_model("idle.d1"); advance();

    // asynchronous reset in the middle of a reuse run
    drive(1, 8'h41, 5, 0, 0); advance();
    drive(0, 8'h00, 0, 1, 0); check_model("rst.s0"); advance();
    drive(0, 8'h00, 0, 1, 0); check_model("rst.s1"); advance();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.calc",   32'(calc_en),              32'd0);
    check("midrst.weight", 32'(weight_out),           32'd0);
    check("midrst.ready",  32'(up_if.weight_ready_o), 32'd1);
    check("midrst.busy",   32'(busy),                 32'd0);
    mq.delete();
    m_used = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 8'h00, 0, 1, 0); check_model("postrst"); advance();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
